dmem_arbiter: RTL

Two-port round-robin arbiter and sequencer for the single-ported data memory (`data`, 64K × 32, one-cycle registered read). It accepts load/store requests from two requesters: port 0 is the CPU load/store stage and port 1 is the debug/DMA loader. It serialises their requests onto the memory's `read`/`write`/`address`/`datain` pins and returns `dataout` with a one-cycle ack. It sits between the requesters and the `data` instance, and is the only driver of the memory's control pins.

---
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port round-robin arbiter and sequencer for the single-ported data memory
// (64K x 32, one-cycle registered read). Port 0 is the CPU load/store stage,
// port 1 is the debug/DMA loader. Requests are serialised onto the memory
// pins; each completes with a one-cycle ack carrying load data.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   req0/1, we0/1           request (held until ack), 1 = store / 0 = load
//   addr0/1, wdata0/1       word address and store data
//   ack0/1, rdata0/1        completion pulse and load data (0 unless acked load)
//   mem_read, mem_write     memory strobes, high only in ISSUE
//   mem_address, mem_datain latched address/data towards the memory
//   mem_dataout             registered read data from the memory
//   busy, grant             state != IDLE, index of the latched winner
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_datain,
   input  logic [DATA_W-1:0] mem_dataout,
   output logic              busy,
   output logic              grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                g_q, g_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                last_q, last_d;

   logic                pick_s;
   logic                pick_v_s;

   // Arbitration: in IDLE both ports compete (tie goes to the port that did
   // not win last); in RESP only the non-granted port may chain back-to-back.
   always_comb begin
      pick_s   = 1'b0;
      pick_v_s = 1'b0;
      if (state_q == IDLE) begin
         pick_v_s = req0 | req1;
         if (req0 & req1) begin
            pick_s = ~last_q;
         end else begin
            pick_s = req1;
         end
      end else if (state_q == RESP) begin
         pick_s   = ~g_q;
         pick_v_s = g_q ? req0 : req1;
      end else begin
         pick_s   = 1'b0;
         pick_v_s = 1'b0;
      end
   end

   // Next-state, latching of the winner and all combinational outputs.
   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      last_d    = last_q;
      ack0      = 1'b0;
      ack1      = 1'b0;
      rdata0    = {DATA_W{1'b0}};
      rdata1    = {DATA_W{1'b0}};
      mem_read  = 1'b0;
      mem_write = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_v_s) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            mem_read  = ~we_q;
            // Gated so a reset landing in ISSUE never commits a store.
            mem_write = we_q & ~reset;
            state_d   = RESP;
         end
         RESP: begin
            if (g_q) begin
               ack1 = 1'b1;
               if (!we_q) begin
                  rdata1 = mem_dataout;
               end else begin
                  rdata1 = {DATA_W{1'b0}};
               end
            end else begin
               ack0 = 1'b1;
               if (!we_q) begin
                  rdata0 = mem_dataout;
               end else begin
                  rdata0 = {DATA_W{1'b0}};
               end
            end
            last_d = g_q;
            if (pick_v_s) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (pick_v_s) begin
         g_d     = pick_s;
         we_d    = pick_s ? we1    : we0;
         addr_d  = pick_s ? addr1  : addr0;
         wdata_d = pick_s ? wdata1 : wdata0;
      end else begin
         g_d     = g_q;
         we_d    = we_q;
         addr_d  = addr_q;
         wdata_d = wdata_q;
      end
   end

   assign mem_address = addr_q;
   assign mem_datain  = wdata_q;
   assign busy        = (state_q != IDLE);
   assign grant       = g_q;

   // State and latched-request registers; last starts at 1 so port 0 wins the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         g_q     <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
      end
   end

endmodule
